udp_line_scheduler: RTL

- Sequences the UDP line-transmit path: arbitrates between per-camera "line ready" requests, issues one transmit trigger with a packet index, then waits for the packet engine to finish.
- Enforces an inter-packet gap and a completion watchdog.
- Sits in the rgmii_clk domain between the per-camera line buffers (requesters) and the UDP packet engine (shared resource).
- Replaces fixed-rate triggering, so that no line is dropped when both cameras are ready at the same time.

---
 rtl/udp_line_scheduler_if.sv | 36 +++
 rtl/udp_line_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/udp_line_scheduler_if.sv
// Handshake bundle between the per-camera line buffers, the line scheduler
// and the UDP packet engine. The scheduler takes the master view; the
// requesters and packet engine together take the slave view.
interface udp_line_scheduler_if #(
  parameter int N_CAM = 2,
  parameter int ROW_W = 11,
  parameter int ID_W  = 5
);
  // Requester side: one level request and one row number per camera.
  logic [N_CAM-1:0]       req;
  logic [N_CAM*ROW_W-1:0] req_row;
  logic [N_CAM-1:0]       ack;

  // Packet engine side: start pulse, packet index, completion pulse.
  logic                   tx_trig;
  logic [ID_W+ROW_W-1:0]  tx_index;
  logic                   tx_done;

  modport master (
    input  req,
    input  req_row,
    input  tx_done,
    output ack,
    output tx_trig,
    output tx_index
  );

  modport slave (
    output req,
    output req_row,
    output tx_done,
    input  ack,
    input  tx_trig,
    input  tx_index
  );
endinterface

// File: rtl/udp_line_scheduler.sv
// UDP line-transmit scheduler. Arbitrates round-robin between camera
// "line ready" requests, fires one transmit trigger carrying {camera, row},
// waits for the packet engine to report completion (or for the watchdog to
// expire) and then holds off for a fixed inter-packet gap. Exactly one
// packet is in flight at any time. All outputs are registered.
module udp_line_scheduler #(
  parameter int N_CAM      = 2,
  parameter int ROW_W      = 11,
  parameter int ID_W       = 5,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  udp_line_scheduler_if.master bus,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          sent_cnt
);

  // Width of a camera number; a single camera still needs one bit.
  localparam int CAM_W = (N_CAM > 1) ? $clog2(N_CAM) : 1;
  // Watchdog counts 0..TIMEOUT-1 inside WAIT (TIMEOUT >= 2).
  localparam int WD_W  = $clog2(TIMEOUT);
  // Gap counter counts 0..GAP_CYCLES-1 inside GAP (GAP_CYCLES >= 1).
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CAM_W-1:0] LAST_RST = CAM_W'(N_CAM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_GAP
  } state_t;

  state_t state;
  state_t state_next;

  // Round-robin pointer: camera granted most recently.
  logic [CAM_W-1:0] last;

  // Arbiter results for the current cycle.
  logic             grant_found;
  logic [CAM_W-1:0] grant;
  logic [N_CAM-1:0] grant_onehot;
  logic [ROW_W-1:0] grant_row;

  // FSM strobes consumed by the datapath.
  logic do_grant;
  logic wait_done;
  logic wait_expire;

  // Watchdog and gap counters.
  logic [WD_W-1:0]  wd;
  logic [GAP_W-1:0] gap;

  // Round-robin search upward from the camera after the last one granted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant_found  = 1'b0;
    grant        = '0;
    grant_onehot = '0;
    grant_row    = '0;
    for (int i = 1; i <= N_CAM; i++) begin
      int c;
      c = (int'(last) + i) % N_CAM;
      if (!grant_found && bus.req[c]) begin
        grant_found     = 1'b1;
        grant           = CAM_W'(c);
        grant_row       = bus.req_row[c*ROW_W +: ROW_W];
        grant_onehot[c] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the one-cycle strobes that drive the datapath.
  always_comb begin
    state_next  = state;
    do_grant    = 1'b0;
    wait_done   = 1'b0;
    wait_expire = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && grant_found) begin
          do_grant   = 1'b1;
          state_next = S_TRIG;
        end
      end
      S_TRIG: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a watchdog expiry on the same edge.
        if (bus.tx_done) begin
          wait_done  = 1'b1;
          state_next = S_GAP;
        end else if (wd == WD_LAST) begin
          wait_expire = 1'b1;
          state_next  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap == GAP_LAST) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs, round-robin pointer, watchdog and gap counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.ack      <= '0;
      bus.tx_trig  <= 1'b0;
      bus.tx_index <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      sent_cnt     <= '0;
      last         <= LAST_RST;
      wd           <= '0;
      gap          <= '0;
    end else begin
      // ack and tx_trig are single-cycle pulses unless re-asserted below.
      bus.ack     <= '0;
      bus.tx_trig <= (state == S_TRIG);
      busy        <= (state_next != S_IDLE);

      if (do_grant) begin
        bus.ack      <= grant_onehot;
        bus.tx_index <= {ID_W'(grant), grant_row};
        last         <= grant;
      end

      unique case (state)
        S_TRIG: wd <= '0;
        S_WAIT: begin
          wd  <= wd + WD_W'(1);
          gap <= '0;
        end
        S_GAP:  gap <= gap + GAP_W'(1);
        default: begin
        end
      endcase

      if (wait_done) begin
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (wait_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
